// File: rtl/rng_capture_pkg.sv
// rng_capture_pkg: shared definitions for the rng_capture slice.
//   state_e        - controller states
//   ram_cmd_e      - command handed to the registered RAM-pin driver
//   *_DEF          - default word / address widths
//   capture_len_ok - legal-range check for the burst length
package rng_capture_pkg;

  localparam int unsigned NUM_BITS_DEF   = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_CAP_FLUSH,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RD_HOLD
  } state_e;

  typedef enum logic [1:0] {
    RAM_NOP,
    RAM_WRITE,
    RAM_READ
  } ram_cmd_e;

  // A burst must hold at least one word and fit in the RAM address space.
  function automatic bit capture_len_ok(input longint len, input longint addr_width);
    return (len >= 1) && (len <= (longint'(1) << addr_width));
  endfunction

endpackage

// File: rtl/rng_capture_if.sv
// rng_capture_if: single-port RAM bus between rng_capture and ram.
//   cs, we, oe  - chip select / write enable / output enable
//   address     - word address
//   data_in     - write data (toward RAM)
//   data_out    - read data (from RAM, one cycle after cs&oe is sampled)
// Modports: master (rng_capture side), slave (RAM side).
interface rng_capture_if
  import rng_capture_pkg::*;
#(
  parameter int NUM_BITS   = NUM_BITS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) ();

  logic                  cs;
  logic                  we;
  logic                  oe;
  logic [ADDR_WIDTH-1:0] address;
  logic [NUM_BITS-1:0]   data_in;
  logic [NUM_BITS-1:0]   data_out;

  modport master (
    output cs, we, oe, address, data_in,
    input  data_out
  );

  modport slave (
    input  cs, we, oe, address, data_in,
    output data_out
  );

endinterface

// File: rtl/rng_capture_ramif.sv
// rng_capture_ramif: registered RAM-pin driver.
//   clk, rst  - clock, synchronous active-high reset
//   cmd_i     - RAM_WRITE / RAM_READ / RAM_NOP for the next cycle
//   addr_i    - address latched with a write or read command
//   wdata_i   - data latched with a write command
//   ram       - RAM bus (master modport); all pins registered
// address/data_in hold their last value on NOP cycles.
module rng_capture_ramif
  import rng_capture_pkg::*;
#(
  parameter int NUM_BITS   = NUM_BITS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  ram_cmd_e              cmd_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_BITS-1:0]   wdata_i,
  rng_capture_if.master         ram
);

  logic                  cs_q;
  logic                  we_q;
  logic                  oe_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [NUM_BITS-1:0]   wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      oe_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (cmd_i)
        RAM_WRITE: begin
          cs_q    <= 1'b1;
          we_q    <= 1'b1;
          oe_q    <= 1'b0;
          addr_q  <= addr_i;
          wdata_q <= wdata_i;
        end
        RAM_READ: begin
          cs_q   <= 1'b1;
          we_q   <= 1'b0;
          oe_q   <= 1'b1;
          addr_q <= addr_i;
        end
        default: begin
          cs_q <= 1'b0;
          we_q <= 1'b0;
          oe_q <= 1'b0;
        end
      endcase
    end
  end

  assign ram.cs      = cs_q;
  assign ram.we      = we_q;
  assign ram.oe      = oe_q;
  assign ram.address = addr_q;
  assign ram.data_in = wdata_q;

endmodule

// File: rtl/rng_capture.sv
// rng_capture: stream sink for mt19937 words; writes a CAPTURE_LEN burst
// into a single-port RAM and reads it back onto an output stream.
//   clk, rst            - clock, synchronous active-high reset
//   r_num, valid, ready - generator stream (ready high only in CAPTURE)
//   cap_start, rd_start - one-cycle start pulses, honoured only in IDLE
//   busy, done          - not-IDLE flag, burst-complete pulse
//   ram                 - RAM bus (cs/we/oe/address/data_in/data_out)
//   out_data, out_valid, out_ready - readback stream
// Optional (RNG_CAPTURE_CHECKSUM_EN):
//   checksum - running XOR of captured words
//   chk_ok   - on the readback done cycle, readback XOR == checksum
module rng_capture
  import rng_capture_pkg::*;
#(
  parameter int NUM_BITS    = NUM_BITS_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int CAPTURE_LEN = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BITS-1:0] r_num,
  input  logic                valid,
  output logic                ready,
  input  logic                cap_start,
  input  logic                rd_start,
  output logic                busy,
  output logic                done,
  rng_capture_if.master       ram,
  output logic [NUM_BITS-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready
`ifdef RNG_CAPTURE_CHECKSUM_EN
  ,
  output logic [NUM_BITS-1:0] checksum,
  output logic                chk_ok
`endif
);

  if (!capture_len_ok(CAPTURE_LEN, ADDR_WIDTH)) begin : g_bad_len
    $error("rng_capture: CAPTURE_LEN must be in 1 .. 2**ADDR_WIDTH");
  end

  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(CAPTURE_LEN - 1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic                  done_q;
  logic                  out_valid_q;
  logic [NUM_BITS-1:0]   out_data_q;

  logic                  last;
  logic                  cap_go;
  logic                  rd_go;
  logic                  wr_hs;
  logic                  rd_acc;
  ram_cmd_e              ram_cmd;
  logic [ADDR_WIDTH-1:0] ram_addr;

  assign last   = (ptr_q == LAST_PTR);
  assign cap_go = (state_q == ST_IDLE) && cap_start;
  assign rd_go  = (state_q == ST_IDLE) && !cap_start && rd_start;
  assign wr_hs  = (state_q == ST_CAPTURE) && valid;
  assign rd_acc = (state_q == ST_RD_HOLD) && out_ready;

  // The pin driver registers its command, so commands are chosen on the
  // transition: a read is issued while entering RD_ISSUE, so its pins are
  // live during RD_ISSUE and data_out is ready to latch in RD_WAIT.
  always_comb begin
    ram_cmd  = RAM_NOP;
    ram_addr = ptr_q;
    if (wr_hs) begin
      ram_cmd = RAM_WRITE;
    end else if (rd_go) begin
      ram_cmd  = RAM_READ;
      ram_addr = '0;
    end else if (rd_acc && !last) begin
      ram_cmd  = RAM_READ;
      ram_addr = ptr_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cap_start) begin
            ptr_q   <= '0;
            state_q <= ST_CAPTURE;
          end else if (rd_start) begin
            ptr_q   <= '0;
            state_q <= ST_RD_ISSUE;
          end
        end
        ST_CAPTURE: begin
          if (valid) begin
            // ptr stops at the last index so it never wraps at full depth.
            if (last) state_q <= ST_CAP_FLUSH;
            else      ptr_q   <= ptr_q + ADDR_WIDTH'(1);
          end
        end
        ST_CAP_FLUSH: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        ST_RD_ISSUE: begin
          state_q <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          out_data_q  <= ram.data_out;
          out_valid_q <= 1'b1;
          state_q     <= ST_RD_HOLD;
        end
        ST_RD_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (last) begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              ptr_q   <= ptr_q + ADDR_WIDTH'(1);
              state_q <= ST_RD_ISSUE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef RNG_CAPTURE_CHECKSUM_EN
  logic [NUM_BITS-1:0] checksum_q;
  logic [NUM_BITS-1:0] rd_xor_q;
  logic                chk_ok_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= '0;
      rd_xor_q   <= '0;
      chk_ok_q   <= 1'b0;
    end else begin
      chk_ok_q <= 1'b0;
      if (cap_go) checksum_q <= '0;
      if (wr_hs)  checksum_q <= checksum_q ^ r_num;
      if (rd_go)  rd_xor_q   <= '0;
      if (state_q == ST_RD_WAIT) rd_xor_q <= rd_xor_q ^ ram.data_out;
      if (rd_acc && last) chk_ok_q <= (rd_xor_q == checksum_q);
    end
  end

  assign checksum = checksum_q;
  assign chk_ok   = chk_ok_q;
`endif

  rng_capture_ramif #(
    .NUM_BITS  (NUM_BITS),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ramif (
    .clk    (clk),
    .rst    (rst),
    .cmd_i  (ram_cmd),
    .addr_i (ram_addr),
    .wdata_i(r_num),
    .ram    (ram)
  );

  assign ready     = (state_q == ST_CAPTURE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
